// File: rtl/y86_inst_encoder.sv
// Y86 instruction encoder: packs icode/ifun/rA/rB/valC into 1-6 little-endian bytes with addresses.
// Optional build macro ENC_REGCHK_EN rejects register ids 8-E in the byte-1 register fields.
module y86_inst_encoder #(
    parameter int unsigned          ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic [31:0]       valC_i,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err_o
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [47:0]         img_q, img_d;
    logic [2:0]          len_q, len_d;
    logic [2:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;

    logic [2:0]          len_c;
    logic [47:0]         img_c;
    logic                reg_bad_c;
    logic                accept_c;
    logic                xfer_c;
    logic                last_c;

    // Instruction length from icode; zero marks an illegal icode.
    always_comb begin
        len_c = 3'd0;
        case (icode_i)
            4'h0, 4'h1, 4'h9:        len_c = 3'd1;
            4'h2, 4'h6, 4'hA, 4'hB:  len_c = 3'd2;
            4'h7, 4'h8:              len_c = 3'd5;
            4'h3, 4'h4, 4'h5:        len_c = 3'd6;
            default:                 len_c = 3'd0;
        endcase
    end

    // Byte image, byte0 in bits [7:0]; unused upper bytes are zero.
    always_comb begin
        img_c = '0;
        case (len_c)
            3'd1:    img_c = {40'h0, icode_i, ifun_i};
            3'd2:    img_c = {32'h0, rA_i, rB_i, icode_i, ifun_i};
            3'd5:    img_c = {8'h0, valC_i, icode_i, ifun_i};
            3'd6:    img_c = {valC_i, rA_i, rB_i, icode_i, ifun_i};
            default: img_c = '0;
        endcase
    end

`ifdef ENC_REGCHK_EN
    // Ids 8-E are not registers; F (none) is accepted.
    always_comb begin
        reg_bad_c = 1'b0;
        if (len_c == 3'd2 || len_c == 3'd6) begin
            reg_bad_c = (rA_i[3] && rA_i != 4'hF) || (rB_i[3] && rB_i != 4'hF);
        end
    end
`else
    assign reg_bad_c = 1'b0;
`endif

    assign accept_c = (state_q == S_IDLE) && in_valid;
    assign last_c   = (state_q == S_EMIT) && (idx_q == 3'(len_q - 3'd1));
    assign xfer_c   = (state_q == S_EMIT) && out_ready;

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (addr_load) begin
                    addr_d = addr_val;
                end
                if (in_valid) begin
                    if (len_c == 3'd0 || reg_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_EMIT;
                        img_d   = img_c;
                        len_d   = len_c;
                        idx_d   = 3'd0;
                    end
                end
            end
            S_EMIT: begin
                if (xfer_c) begin
                    addr_d = addr_q + 1'b1;
                    if (last_c) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            img_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        out_byte = '0;
        if (state_q == S_EMIT) begin
            case (idx_q)
                3'd0:    out_byte = img_q[7:0];
                3'd1:    out_byte = img_q[15:8];
                3'd2:    out_byte = img_q[23:16];
                3'd3:    out_byte = img_q[31:24];
                3'd4:    out_byte = img_q[39:32];
                3'd5:    out_byte = img_q[47:40];
                default: out_byte = '0;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_EMIT);
    assign out_last  = last_c;
    assign out_addr  = addr_q;
    assign err_o     = err_q;

    // accept_c is the acceptance handshake; kept named for readability of the IDLE branch.
    logic unused_accept;
    assign unused_accept = accept_c;

endmodule

// File: tb/tb_y86_inst_encoder.sv
// Directed self-checking bench for y86_inst_encoder (honours ENC_REGCHK_EN when defined).
module tb_y86_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode_i, ifun_i, rA_i, rB_i;
    logic [31:0] valC_i;
    logic        addr_load;
    logic [15:0] addr_val;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [15:0] out_addr;
    logic        out_last;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] a;

    y86_inst_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .icode_i(icode_i), .ifun_i(ifun_i), .rA_i(rA_i), .rB_i(rB_i), .valC_i(valC_i),
        .addr_load(addr_load), .addr_val(addr_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_addr(out_addr), .out_last(out_last),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [31:0] vc);
        icode_i  = ic; ifun_i = fn; rA_i = ra; rB_i = rb; valC_i = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        icode_i  = 4'hC;
    endtask

    task automatic emit(input string tag, input logic [7:0] b, input logic [15:0] ad, input logic l);
        out_ready = 1'b1;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_byte"},  out_byte, b);
        chk({tag, "_addr"},  out_addr, ad);
        chk({tag, "_last"},  out_last, l);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_val = '0;
        icode_i = '0; ifun_i = '0; rA_i = '0; rB_i = '0; valC_i = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_addr", out_addr, 16'h0000);
        chk("rst_byte", out_byte, 8'h00);
        chk("rst_last", out_last, 1'b0);
        tick();
        chk("idle_out_valid", out_valid, 1'b0);

        // irmovl $0x12345678, %edx
        send(4'h3, 4'h0, 4'hF, 4'h2, 32'h12345678);
        chk("irm_in_ready", in_ready, 1'b0);
        emit("irm0", 8'h30, 16'h0000, 1'b0);
        emit("irm1", 8'hF2, 16'h0001, 1'b0);
        emit("irm2", 8'h78, 16'h0002, 1'b0);
        emit("irm3", 8'h56, 16'h0003, 1'b0);
        emit("irm4", 8'h34, 16'h0004, 1'b0);
        emit("irm5", 8'h12, 16'h0005, 1'b1);
        chk("irm_done_ready", in_ready, 1'b1);
        chk("irm_done_valid", out_valid, 1'b0);
        chk("irm_done_addr", out_addr, 16'h0006);

        // call 0x40 with a stall before every byte; addr_load in EMIT is ignored
        send(4'h8, 4'h0, 4'h0, 4'h0, 32'h00000040);
        addr_load = 1'b1; addr_val = 16'h1234;
        tick();
        addr_load = 1'b0;
        chk("call_stall_byte", out_byte, 8'h80);
        chk("call_stall_addr", out_addr, 16'h0006);
        chk("call_stall_valid", out_valid, 1'b1);
        emit("call0", 8'h80, 16'h0006, 1'b0);
        tick();
        chk("call_hold1_byte", out_byte, 8'h40);
        chk("call_hold1_addr", out_addr, 16'h0007);
        emit("call1", 8'h40, 16'h0007, 1'b0);
        tick();
        chk("call_hold2_addr", out_addr, 16'h0008);
        emit("call2", 8'h00, 16'h0008, 1'b0);
        emit("call3", 8'h00, 16'h0009, 1'b0);
        tick();
        chk("call_hold4_last", out_last, 1'b1);
        chk("call_hold4_addr", out_addr, 16'h000A);
        emit("call4", 8'h00, 16'h000A, 1'b1);
        chk("call_done_addr", out_addr, 16'h000B);
        chk("call_done_ready", in_ready, 1'b1);

        // addr_load with simultaneous opl: first byte uses the loaded address, then wrap
        addr_load = 1'b1; addr_val = 16'hFFFE;
        send(4'h6, 4'h1, 4'h0, 4'h3, 32'hDEADBEEF);
        addr_load = 1'b0;
        emit("opl0", 8'h61, 16'hFFFE, 1'b0);
        emit("opl1", 8'h03, 16'hFFFF, 1'b1);
        send(4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
        emit("halt0", 8'h00, 16'h0000, 1'b1);
        chk("halt_done_addr", out_addr, 16'h0001);

        // illegal icode D
        send(4'hD, 4'h0, 4'h1, 4'h2, 32'h0);
        chk("ill_err", err_o, 1'b1);
        chk("ill_valid", out_valid, 1'b0);
        chk("ill_ready", in_ready, 1'b1);
        chk("ill_addr", out_addr, 16'h0001);
        tick();
        chk("ill_err_pulse", err_o, 1'b0);
        chk("ill_valid2", out_valid, 1'b0);

        // rrmovl with rA=9
        a = 16'h0001;
        send(4'h2, 4'h0, 4'h9, 4'hF, 32'h0);
`ifdef ENC_REGCHK_EN
        chk("rr9_err", err_o, 1'b1);
        chk("rr9_valid", out_valid, 1'b0);
        chk("rr9_addr", out_addr, a);
        tick();
        chk("rr9_err_pulse", err_o, 1'b0);
`else
        chk("rr9_err", err_o, 1'b0);
        emit("rr9_0", 8'h20, a, 1'b0);
        emit("rr9_1", 8'h9F, a + 16'd1, 1'b1);
        a = a + 16'd2;
`endif

        // mrmovl aborted by reset after two bytes
        send(4'h5, 4'h0, 4'h1, 4'h2, 32'h00000100);
        emit("mrm0", 8'h50, a, 1'b0);
        emit("mrm1", 8'h12, a + 16'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_addr", out_addr, 16'h0000);
        chk("abort_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("abort_no_bytes", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
